host_cmd_mstr: RTL

//  Host-side command master for the DSO_dig UART protocol; sits between bench/host logic and a byte UART (UART_comm).

---
 rtl/host_cmd_mstr.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/host_cmd_mstr.sv
// rtl/host_cmd_mstr.sv - host-side command master: 3-byte command out, response stream in, with NAK and watchdog flags
module host_cmd_mstr #(
  parameter int DUMP_LEN    = 510,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cmd,
  input  logic        send_cmd,
  output logic        busy,
  output logic        cmd_sent,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic [9:0]  resp_cnt,
  output logic        xfer_done,
  output logic        nak,
  output logic        timeout
);

  localparam int              WD_BITS  = $clog2(TIMEOUT_CYC);
  localparam int              WD_W     = (WD_BITS < 1) ? 1 : WD_BITS;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [9:0]      DUMP_CNT = 10'(DUMP_LEN);
  localparam logic [7:0]      OP_DUMP  = 8'h01;
  localparam logic [7:0]      ACK      = 8'hA5;
  localparam logic [9:0]      CNT_MAX  = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    TX_LOAD,
    TX_WAIT,
    RX_WAIT,
    RX_HOLD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [23:0]     cmd_q;
  logic [1:0]      idx;
  logic [9:0]      exp_cnt;
  logic [WD_W-1:0] wd;

  // one-cycle event strobes decoded from the current state and inputs
  logic accept;
  logic tx_adv;
  logic tx_last;
  logic rx_take;
  logic wd_expire;
  logic rx_last;
  logic nak_op;

  // opcodes whose single reply byte must be the ack; data-bearing reads are excluded
  always_comb begin
    nak_op = cmd_q[23:16] inside {8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08};
  end

  // next-state decode; an arriving byte takes priority over watchdog expiry
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tx_adv    = 1'b0;
    tx_last   = 1'b0;
    rx_take   = 1'b0;
    wd_expire = 1'b0;
    rx_last   = 1'b0;
    case (state)
      IDLE: begin
        if (send_cmd) begin
          accept    = 1'b1;
          state_nxt = TX_LOAD;
        end
      end
      TX_LOAD: begin
        // tx_done is not looked at in the strobe cycle; the UART clears it on trmt
        state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (idx == 2'd2) begin
            tx_last   = 1'b1;
            state_nxt = RX_WAIT;
          end else begin
            tx_adv    = 1'b1;
            state_nxt = TX_LOAD;
          end
        end
      end
      RX_WAIT: begin
        if (rx_rdy && !resp_rdy) begin
          rx_take   = 1'b1;
          state_nxt = RX_HOLD;
        end else if (wd == WD_LAST) begin
          wd_expire = 1'b1;
          state_nxt = IDLE;
        end
      end
      RX_HOLD: begin
        if (clr_resp_rdy) begin
          rx_last   = (resp_cnt == exp_cnt);
          state_nxt = rx_last ? IDLE : RX_WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign trmt = (state == TX_LOAD);

  // command latch, byte sequencing, response capture, sticky flags and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= 24'h0;
      idx        <= 2'd0;
      exp_cnt    <= 10'd1;
      wd         <= '0;
      tx_data    <= 8'h00;
      cmd_sent   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      resp       <= 8'h00;
      resp_rdy   <= 1'b0;
      resp_cnt   <= 10'd0;
      xfer_done  <= 1'b0;
      nak        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      cmd_sent   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      xfer_done  <= 1'b0;

      // host may drop resp_rdy at any time; a new capture below overrides it
      if (clr_resp_rdy) begin
        resp_rdy <= 1'b0;
      end

      if (accept) begin
        cmd_q    <= cmd;
        idx      <= 2'd0;
        tx_data  <= cmd[23:16];
        nak      <= 1'b0;
        timeout  <= 1'b0;
        resp_cnt <= 10'd0;
        exp_cnt  <= (cmd[23:16] == OP_DUMP) ? DUMP_CNT : 10'd1;
      end

      if (tx_adv) begin
        idx     <= idx + 2'd1;
        tx_data <= (idx == 2'd0) ? cmd_q[15:8] : cmd_q[7:0];
      end

      if (tx_last) begin
        cmd_sent <= 1'b1;
        wd       <= '0;
      end

      if (rx_take) begin
        resp       <= rx_data;
        resp_rdy   <= 1'b1;
        clr_rx_rdy <= 1'b1;
        wd         <= '0;
        if (resp_cnt != CNT_MAX) begin
          resp_cnt <= resp_cnt + 10'd1;
        end
        if ((resp_cnt == 10'd0) && nak_op && (rx_data != ACK)) begin
          nak <= 1'b1;
        end
      end else if ((state == RX_WAIT) && !wd_expire) begin
        wd <= wd + 1'b1;
      end

      if (wd_expire) begin
        timeout <= 1'b1;
      end

      if (rx_last) begin
        xfer_done <= 1'b1;
      end
    end
  end

endmodule
